fifo_golden_checker: RTL and testbench

//  Synthesizable cycle-accurate reference model and checker for the synchronous FIFO.

---
 rtl/fifo_golden_checker.sv | 141 ++++++++++++++
 tb/tb_fifo_golden_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_golden_checker.sv
// fifo_golden_checker: cycle-accurate reference model of the synchronous FIFO.
// It tracks the FIFO from the DUT's own inputs and compares every DUT output
// on each enabled cycle. Results are a registered mismatch pulse, per-field
// fail bits, a sticky error flag, and saturating pass/fail counters.
module fifo_golden_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  chk_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    output logic                  mismatch,
    output logic [8:0]            mismatch_vec,
    output logic                  err_flag,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  correct_count
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

    // One snapshot of everything the FIFO presents. The same layout is used for
    // the DUT view and for the model view.
    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data_out;
        logic                  wr_ack;
        logic                  overflow;
        logic                  underflow;
        logic                  full;
        logic                  empty;
        logic                  almostfull;
        logic                  almostempty;
    } obs_t;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [FIFO_WIDTH-1:0] m_data_out;
    logic                  m_wr_ack, m_overflow, m_underflow;
    logic                  m_full, m_empty;
    logic                  wr_acc, rd_acc;
    obs_t                  dut_obs, mdl_obs;
    logic [8:0]            fail_vec;
    logic                  any_fail;

    assign m_full  = (count == DEPTH_C);
    assign m_empty = (count == '0);
    // Accepting against the current count gives the full/empty corner cases
    // directly: both requests at full is read-only, and at empty it is write-only.
    assign wr_acc  = wr_en & ~m_full;
    assign rd_acc  = rd_en & ~m_empty;

    assign dut_obs = '{data_out, wr_ack, overflow, underflow, full, empty,
                       almostfull, almostempty};
    assign mdl_obs = '{m_data_out, m_wr_ack, m_overflow, m_underflow, m_full, m_empty,
                       (count == DEPTH_C - 1'b1), (count == {{PW{1'b0}}, 1'b1})};

    // Per-field compare. Case inequality makes an X or Z on a DUT output
    // count as a failure instead of being masked out.
    assign fail_vec = {dut_obs.data_out    !== mdl_obs.data_out,
                       dut_obs.wr_ack      !== mdl_obs.wr_ack,
                       dut_obs.overflow    !== mdl_obs.overflow,
                       dut_obs.underflow   !== mdl_obs.underflow,
                       dut_obs.full        !== mdl_obs.full,
                       dut_obs.empty       !== mdl_obs.empty,
                       dut_obs.almostfull  !== mdl_obs.almostfull,
                       dut_obs.almostempty !== mdl_obs.almostempty,
                       1'b0};
    assign any_fail = |fail_vec;

    // Model storage. It has no reset, because its contents are never observed
    // until they have been written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    // Model pointers, occupancy and registered outputs.
    // Pointer width is log2(depth), so the wrap from DEPTH-1 to 0 happens on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            m_data_out  <= '0;
            m_wr_ack    <= 1'b0;
            m_overflow  <= 1'b0;
            m_underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + 1'b1;
                m_data_out <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            m_wr_ack    <= wr_acc;
            m_overflow  <= wr_en & m_full;
            m_underflow <= rd_en & m_empty;
        end
    end

    // Compare results and saturating counters. When checking is disabled the
    // pulse outputs clear and the accumulated state holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch      <= 1'b0;
            mismatch_vec  <= '0;
            err_flag      <= 1'b0;
            error_count   <= '0;
            correct_count <= '0;
        end else if (chk_en) begin
            mismatch     <= any_fail;
            mismatch_vec <= fail_vec;
            if (any_fail) begin
                err_flag <= 1'b1;
                if (error_count != '1) error_count <= error_count + 1'b1;
            end else if (correct_count != '1) begin
                correct_count <= correct_count + 1'b1;
            end
        end else begin
            mismatch     <= 1'b0;
            mismatch_vec <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_golden_checker.sv
// Bench for fifo_golden_checker. A behavioural FIFO stands in for the DUT, and
// its outputs can have faults XOR-injected on individual fields. The expected
// compare result is queued when each cycle is driven and popped after the edge.
module tb_fifo_golden_checker;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, chk_en, chk_en4, wr_en, rd_en;
    logic [W-1:0] data_in;
    logic [8:0]   inj;

    // Stand-in FIFO that plays the role of the DUT.
    logic [W-1:0] f_mem [D];
    logic [2:0]   f_wp, f_rp;
    logic [3:0]   f_cnt;
    logic [W-1:0] f_dout;
    logic         f_ack, f_ovf, f_udf, f_wok, f_rok;

    assign f_wok = wr_en && (f_cnt != 4'd8);
    assign f_rok = rd_en && (f_cnt != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wp <= '0; f_rp <= '0; f_cnt <= '0; f_dout <= '0;
            f_ack <= 1'b0; f_ovf <= 1'b0; f_udf <= 1'b0;
        end else begin
            if (f_wok) begin f_mem[f_wp] <= data_in; f_wp <= f_wp + 3'd1; end
            if (f_rok) begin f_dout <= f_mem[f_rp]; f_rp <= f_rp + 3'd1; end
            if (f_wok && !f_rok) f_cnt <= f_cnt + 4'd1;
            else if (f_rok && !f_wok) f_cnt <= f_cnt - 4'd1;
            f_ack <= f_wok;
            f_ovf <= wr_en && (f_cnt == 4'd8);
            f_udf <= rd_en && (f_cnt == 4'd0);
        end
    end

    // DUT-visible outputs with optional per-field faults.
    logic [W-1:0] d_dout;
    logic d_ack, d_ovf, d_udf, d_full, d_empty, d_af, d_ae;
    assign d_dout  = f_dout ^ {{(W-1){1'b0}}, inj[8]};
    assign d_ack   = f_ack ^ inj[7];
    assign d_ovf   = f_ovf ^ inj[6];
    assign d_udf   = f_udf ^ inj[5];
    assign d_full  = (f_cnt == 4'd8) ^ inj[4];
    assign d_empty = (f_cnt == 4'd0) ^ inj[3];
    assign d_af    = (f_cnt == 4'd7) ^ inj[2];
    assign d_ae    = (f_cnt == 4'd1) ^ inj[1];

    logic        mism, eflag, mism4, eflag4;
    logic [8:0]  mvec, mvec4;
    logic [15:0] ecnt, ccnt;
    logic [3:0]  ecnt4, ccnt4;

    fifo_golden_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(16)) u_chk (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .data_in(data_in),
        .wr_en(wr_en), .rd_en(rd_en), .data_out(d_dout), .wr_ack(d_ack),
        .overflow(d_ovf), .underflow(d_udf), .full(d_full), .empty(d_empty),
        .almostfull(d_af), .almostempty(d_ae), .mismatch(mism),
        .mismatch_vec(mvec), .err_flag(eflag), .error_count(ecnt),
        .correct_count(ccnt));

    fifo_golden_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(4)) u_chk4 (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en4), .data_in(data_in),
        .wr_en(wr_en), .rd_en(rd_en), .data_out(d_dout), .wr_ack(d_ack),
        .overflow(d_ovf), .underflow(d_udf), .full(d_full), .empty(d_empty),
        .almostfull(d_af), .almostempty(d_ae), .mismatch(mism4),
        .mismatch_vec(mvec4), .err_flag(eflag4), .error_count(ecnt4),
        .correct_count(ccnt4));

    int ntests = 0;
    int nfail  = 0;

    typedef struct { logic m; logic [8:0] v; } exp_t;
    exp_t sbq[$];
    int   exp_err, exp_ok;
    logic exp_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (called at a negedge), then check what the checker
    // reports for that cycle's compare at the following negedge.
    task automatic cyc(input logic wr, input logic rd, input logic [W-1:0] din,
                       input logic [8:0] fi);
        exp_t e;
        wr_en = wr; rd_en = rd; data_in = din; inj = fi;
        e.m = chk_en && (fi[8:1] != 8'h0);
        e.v = e.m ? {fi[8:1], 1'b0} : 9'h0;
        if (chk_en) begin
            if (e.m) begin exp_err++; exp_flag = 1'b1; end
            else exp_ok++;
        end
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk("mismatch",      32'(mism),  32'(e.m));
        chk("mismatch_vec",  32'(mvec),  32'(e.v));
        chk("err_flag",      32'(eflag), 32'(exp_flag));
        chk("error_count",   32'(ecnt),  32'(exp_err));
        chk("correct_count", 32'(ccnt),  32'(exp_ok));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; chk_en = 1'b1; chk_en4 = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; data_in = '0; inj = '0;
        exp_err = 0; exp_ok = 0; exp_flag = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst mismatch",      32'(mism),  0);
        chk("rst mismatch_vec",  32'(mvec),  0);
        chk("rst err_flag",      32'(eflag), 0);
        chk("rst error_count",   32'(ecnt),  0);
        chk("rst correct_count", 32'(ccnt),  0);
        rst_n = 1'b1;

        // 1: fill with 0x0001..0x0008, then one idle compare with the FIFO full
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(i), 9'h0);
        cyc(1'b0, 1'b0, 16'h0, 9'h0);
        chk("t1 full",          32'(d_full), 1);
        chk("t1 correct_count", 32'(ccnt),   9);
        chk("t1 error_count",   32'(ecnt),   0);

        // 2: overflow on full, then drain with 9 reads
        cyc(1'b1, 1'b0, 16'hdead, 9'h0);
        chk("t2 overflow", 32'(d_ovf), 1);
        chk("t2 wr_ack",   32'(d_ack), 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b1, 16'h0, 9'h0);
            if (i <= 8) chk("t2 read data", 32'(d_dout), 32'(i));
        end
        chk("t2 underflow",   32'(d_udf), 1);
        chk("t2 error_count", 32'(ecnt),  0);

        // 3: data_out fault after the 3rd read
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'(16'h11 + i), 9'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0, 9'h0);
        chk("t3 third read", 32'(d_dout), 32'h13);
        cyc(1'b0, 1'b0, 16'h0, 9'h100);
        chk("t3 mismatch_vec[8]", 32'(mvec[8]), 1);
        cyc(1'b0, 1'b0, 16'h0, 9'h0);
        chk("t3 err_flag",    32'(eflag), 1);
        chk("t3 error_count", 32'(ecnt),  1);
        cyc(1'b0, 1'b1, 16'h0, 9'h0);

        // 4: simultaneous read/write at count 0, 4 and 8, with pointer wrap
        cyc(1'b1, 1'b1, 16'ha0, 9'h0);
        chk("t4 wr_ack at empty",    32'(d_ack), 1);
        chk("t4 underflow at empty", 32'(d_udf), 1);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'(16'ha0 + i), 9'h0);
        cyc(1'b1, 1'b1, 16'ha4, 9'h0);
        chk("t4 both read", 32'(d_dout), 32'ha0);
        chk("t4 both ack",  32'(d_ack),  1);
        for (int i = 5; i <= 8; i++) cyc(1'b1, 1'b0, 16'(16'ha0 + i), 9'h0);
        cyc(1'b1, 1'b1, 16'ha9, 9'h0);
        chk("t4 full read",     32'(d_dout), 32'ha1);
        chk("t4 full overflow", 32'(d_ovf),  1);
        chk("t4 full no ack",   32'(d_ack),  0);

        // 5: async reset in the middle of a write burst at count 5
        cyc(1'b0, 1'b1, 16'h0, 9'h0);
        cyc(1'b0, 1'b1, 16'h0, 9'h0);
        wr_en = 1'b1; rd_en = 1'b0; data_in = 16'hbeef;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async mismatch",      32'(mism),  0);
        chk("t5 async mismatch_vec",  32'(mvec),  0);
        chk("t5 async err_flag",      32'(eflag), 0);
        chk("t5 async error_count",   32'(ecnt),  0);
        chk("t5 async correct_count", 32'(ccnt),  0);
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
        exp_err = 0; exp_ok = 0; exp_flag = 1'b0; sbq.delete();
        cyc(1'b0, 1'b0, 16'h0, 9'h0);
        cyc(1'b0, 1'b1, 16'h0, 9'h0);
        chk("t5 empty after release", 32'(d_empty), 1);

        // 6: saturation of the narrow counter, then freeze with chk_en low
        chk("t6 cnt4 idle", 32'(ecnt4), 0);
        chk_en4 = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 16'h0, 9'h004);
        chk("t6 cnt4 saturated", 32'(ecnt4),  15);
        chk("t6 cnt4 mismatch",  32'(mism4),  1);
        chk("t6 cnt4 vec",       32'(mvec4),  32'h004);
        chk("t6 cnt4 err_flag",  32'(eflag4), 1);
        chk_en = 1'b0; chk_en4 = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 9'h004);
        chk("t6 cnt4 frozen",      32'(ecnt4), 15);
        chk("t6 cnt4 ok frozen",   32'(ccnt4), 0);
        chk("t6 cnt4 no mismatch", 32'(mism4), 0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 16'h0, 9'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
